// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N1 UART transmitter.
//
// Each tx_en strobe pushes tx_data into a small circular FIFO. A baud-rate
// serializer pops bytes from the FIFO and shifts them out on txd with one
// start bit (0), eight data bits sent LSB first, and one stop bit (1). Each
// bit lasts BAUD_DIV clock cycles. The write side has no back-pressure. A
// write that arrives while the FIFO is full (and no pop happens in that
// cycle) is dropped, and overflow then pulses for one cycle.
//
// Parameters:
//   BAUD_DIV   - clock cycles per serial bit (>= 2)
//   FIFO_DEPTH - byte capacity (power of two, >= 2)
//   CW         - width of fifo_count
// Ports:
//   clk        - system clock, rising edge
//   rst        - synchronous active-high reset (aborts frame, flushes FIFO)
//   tx_en      - one-cycle write strobe
//   tx_data    - byte written when tx_en is high
//   txd        - registered serial output, idle high
//   tx_busy    - FIFO non-empty or a frame in progress
//   fifo_full  - fifo_count == FIFO_DEPTH
//   fifo_empty - fifo_count == 0
//   fifo_count - queued bytes, not counting the byte being shifted
//   overflow   - one-cycle pulse after a dropped write
module uart_tx_fifo #(
    parameter int BAUD_DIV   = 434,
    parameter int FIFO_DEPTH = 8,
    parameter int CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tx_en,
    input  logic [7:0]    tx_data,
    output logic          txd,
    output logic          tx_busy,
    output logic          fifo_full,
    output logic          fifo_empty,
    output logic [CW-1:0] fifo_count,
    output logic          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [BW-1:0] bcnt;
    logic [BW-1:0] bcnt_next;
    logic [2:0]    bitidx;
    logic [2:0]    bitidx_next;
    logic          txd_next;
    logic          pop;
    logic          bit_end;
    logic          wr_acc;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [7:0]    shift;

    assign fifo_full  = (fifo_count == CW'(FIFO_DEPTH));
    assign fifo_empty = (fifo_count == '0);
    assign tx_busy    = (state != IDLE) || !fifo_empty;
    assign bit_end    = (bcnt == BAUD_LAST);

    // A pop in the same cycle frees a slot, so a write at full still lands.
    assign wr_acc = tx_en && (!fifo_full || pop);

    // Serializer next-state logic
    always_comb begin
        state_next  = state;
        bcnt_next   = bcnt;
        bitidx_next = bitidx;
        txd_next    = txd;
        pop         = 1'b0;

        case (state)
            IDLE: begin
                txd_next = 1'b1;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    bcnt_next  = '0;
                    txd_next   = 1'b0;
                    state_next = START;
                end
            end
            START: begin
                if (bit_end) begin
                    bcnt_next   = '0;
                    bitidx_next = '0;
                    txd_next    = shift[0];
                    state_next  = DATA;
                end else begin
                    bcnt_next = bcnt + BW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    bcnt_next = '0;
                    if (bitidx != 3'd7) begin
                        bitidx_next = bitidx + 3'd1;
                        txd_next    = shift[bitidx + 3'd1];
                    end else begin
                        txd_next   = 1'b1;
                        state_next = STOP;
                    end
                end else begin
                    bcnt_next = bcnt + BW'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    bcnt_next = '0;
                    // Chain straight into the next start bit when data waits.
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        txd_next   = 1'b0;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    bcnt_next = bcnt + BW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                bcnt_next  = '0;
                txd_next   = 1'b1;
            end
        endcase
    end

    // Serializer state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            bcnt   <= '0;
            bitidx <= '0;
            txd    <= 1'b1;
        end else begin
            state  <= state_next;
            bcnt   <= bcnt_next;
            bitidx <= bitidx_next;
            txd    <= txd_next;
        end
    end

    // Shift register holds the byte in flight; its contents need no reset.
    always_ff @(posedge clk) begin
        if (pop) begin
            shift <= mem[rd_ptr];
        end
    end

    // FIFO pointers, occupancy and drop flag
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_acc, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
            overflow <= tx_en && !wr_acc;
        end
    end

    // FIFO storage; a strobe coinciding with reset is discarded.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[wr_ptr] <= tx_data;
        end
    end

endmodule
